cv32e40x_fencei_flush_unit: RTL and testbench



---
 rtl/cv32e40x_fencei_flush_unit.sv | 125 ++++++++++++
 tb/tb_cv32e40x_fencei_flush_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/cv32e40x_fencei_flush_unit.sv
// fence.i flush responder: blocks fetch, drains outstanding instruction OBI
// transactions, invalidates every tag line, then pulses a one-cycle acknowledge.
module cv32e40x_fencei_flush_unit #(
  parameter int unsigned NUM_LINES       = 16,
  parameter int unsigned MAX_OUTSTANDING = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         fencei_flush_req_i,
  output logic                         fencei_flush_ack_o,
  input  logic                         instr_req_i,
  input  logic                         instr_gnt_i,
  input  logic                         instr_rvalid_i,
  output logic                         fetch_block_o,
  output logic                         inval_req_o,
  output logic [$clog2(NUM_LINES)-1:0] inval_idx_o,
  input  logic                         inval_gnt_i,
  output logic                         busy_o,
  output logic                         err_o
);

  localparam int unsigned IDX_W = $clog2(NUM_LINES);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LINES - 1);
  localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_OUTSTANDING);

  // Invalidate handshake: inval_req_o holds with a stable inval_idx_o until
  // inval_gnt_i is seen high at a rising clock edge; that edge retires the line.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DRAIN   = 3'd1,
    INVAL   = 3'd2,
    ACK     = 3'd3,
    RELEASE = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               err_q, err_d;
  logic               cnt_inc, cnt_dec;

  assign cnt_inc = instr_req_i & instr_gnt_i;
  assign cnt_dec = instr_rvalid_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
    end
  end

  // Outstanding counter runs in every state; out-of-range moves are clamped
  // and flagged instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    err_d = err_q;
    unique case ({cnt_inc, cnt_dec})
      2'b10: begin
        if (cnt_q == MAX_CNT) err_d = 1'b1;
        else                  cnt_d = cnt_q + CNT_W'(1);
      end
      2'b01: begin
        if (cnt_q == '0) err_d = 1'b1;
        else             cnt_d = cnt_q - CNT_W'(1);
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      IDLE: begin
        if (fencei_flush_req_i) state_d = DRAIN;
      end
      DRAIN: begin
        if (cnt_d == '0) begin
          state_d = INVAL;
          idx_d   = '0;
        end
      end
      INVAL: begin
        if (inval_gnt_i) begin
          if (idx_q == LAST_IDX) begin
            state_d = ACK;
            idx_d   = '0;
          end else begin
            idx_d = idx_q + IDX_W'(1);
          end
        end
      end
      ACK: begin
        state_d = RELEASE;
      end
      RELEASE: begin
        if (!fencei_flush_req_i) state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
      end
    endcase
  end

  // Pure decodes of registered state, so reset clears every output at once.
  always_comb begin
    fencei_flush_ack_o = (state_q == ACK);
    inval_req_o        = (state_q == INVAL);
    inval_idx_o        = idx_q;
    fetch_block_o      = (state_q != IDLE);
    busy_o             = (state_q != IDLE);
    err_o              = err_q;
  end

endmodule

// File: tb/tb_cv32e40x_fencei_flush_unit.sv
// Directed bench for the fence.i flush responder; cycle 0 is the cycle in
// which the flush request is first driven high.
module tb_cv32e40x_fencei_flush_unit;

  localparam int NL = 16;
  localparam int MO = 2;
  localparam int IW = $clog2(NL);

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          fencei_req = 1'b0;
  logic          fencei_ack;
  logic          instr_req = 1'b0;
  logic          instr_gnt = 1'b0;
  logic          instr_rvalid = 1'b0;
  logic          fetch_block;
  logic          inval_req;
  logic [IW-1:0] inval_idx;
  logic          inval_gnt = 1'b1;
  logic          busy;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  cv32e40x_fencei_flush_unit #(
    .NUM_LINES      (NL),
    .MAX_OUTSTANDING(MO)
  ) u_dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .fencei_flush_req_i(fencei_req),
    .fencei_flush_ack_o(fencei_ack),
    .instr_req_i       (instr_req),
    .instr_gnt_i       (instr_gnt),
    .instr_rvalid_i    (instr_rvalid),
    .fetch_block_o     (fetch_block),
    .inval_req_o       (inval_req),
    .inval_idx_o       (inval_idx),
    .inval_gnt_i       (inval_gnt),
    .busy_o            (busy),
    .err_o             (err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ack"},   32'(fencei_ack),  0);
    check({tag, "_fblk"},  32'(fetch_block), 0);
    check({tag, "_ireq"},  32'(inval_req),   0);
    check({tag, "_idx"},   32'(inval_idx),   0);
    check({tag, "_busy"},  32'(busy),        0);
    check({tag, "_err"},   32'(err),         0);
  endtask

  task automatic handshakes(input int n);
    instr_req = 1'b1;
    instr_gnt = 1'b1;
    repeat (n) tick();
    instr_req = 1'b0;
    instr_gnt = 1'b0;
  endtask

  // Raises req in the current cycle and runs until ack. rv_a/rv_b: rvalid
  // cycles, hs_c: instr handshake cycle, gnt held low for lo_len cycles on
  // line lo_idx. The expected index advances only on a driven grant.
  task automatic flush_run(input int rv_a, input int rv_b, input int hs_c,
                           input int lo_idx, input int lo_len,
                           output int first_inval, output int ack_cyc);
    int lo_left;
    int exp_idx;
    lo_left     = lo_len;
    exp_idx     = 0;
    first_inval = -1;
    ack_cyc     = -1;
    fencei_req  = 1'b1;
    for (int c = 0; c < 100; c++) begin
      if (fencei_ack) begin
        ack_cyc = c;
        break;
      end
      if (c == 1) check("drain_busy", 32'(busy & fetch_block), 1);
      if (inval_req && first_inval < 0) first_inval = c;
      if (inval_req) check("idx_seq", 32'(inval_idx), 32'(exp_idx));
      instr_rvalid = (c == rv_a) || (c == rv_b);
      instr_req    = (c == hs_c);
      instr_gnt    = (c == hs_c);
      if (inval_req && int'(inval_idx) == lo_idx && lo_left > 0) begin
        inval_gnt = 1'b0;
        lo_left--;
      end else begin
        inval_gnt = 1'b1;
        if (inval_req) exp_idx++;
      end
      tick();
    end
    instr_rvalid = 1'b0;
    instr_req    = 1'b0;
    instr_gnt    = 1'b0;
    inval_gnt    = 1'b1;
    if (ack_cyc < 0) check("ack_timeout", 0, 1);
  endtask

  // Called in the ack cycle; holds req for 'held' cycles after ack, then drops it.
  task automatic finish_flush(input int held);
    tick();
    for (int i = 1; i <= held; i++) begin
      check("rel_busy",  32'(busy),       1);
      check("rel_ack",   32'(fencei_ack), 0);
      check("rel_ireq",  32'(inval_req),  0);
      if (i == held) fencei_req = 1'b0;
      tick();
    end
    check("idle_busy", 32'(busy),        0);
    check("idle_fblk", 32'(fetch_block), 0);
  endtask

  initial begin
    int fi;
    int ac;
    bit hit;

    // Reset
    tick();
    check_all_zero("reset");
    rst_n = 1'b1;
    tick();

    // Idle flush: inval cycles 2..17, ack at 18
    flush_run(-1, -1, -1, -1, 0, fi, ac);
    check("idle_first_inval", 32'(fi), 2);
    check("idle_ack_cyc",     32'(ac), 18);
    finish_flush(1);

    // Drain: two outstanding, rvalids at 3 and 5
    handshakes(2);
    flush_run(3, 5, -1, -1, 0, fi, ac);
    check("drain_first_inval", 32'(fi), 6);
    check("drain_ack_cyc",     32'(ac), 22);
    check("drain_err",         32'(err), 0);
    finish_flush(1);

    // Invalidate backpressure on line 7 for 4 cycles
    flush_run(-1, -1, -1, 7, 4, fi, ac);
    check("bp_first_inval", 32'(fi), 2);
    check("bp_ack_cyc",     32'(ac), 22);
    finish_flush(1);

    // cnt=1, simultaneous handshake+rvalid at 2, lone rvalid at 4
    handshakes(1);
    flush_run(2, 4, 2, -1, 0, fi, ac);
    check("simul_first_inval", 32'(fi), 5);
    check("simul_ack_cyc",     32'(ac), 21);
    check("simul_err",         32'(err), 0);
    finish_flush(1);

    // Held request after ack
    flush_run(-1, -1, -1, -1, 0, fi, ac);
    check("held_ack_cyc", 32'(ac), 18);
    finish_flush(6);
    tick();
    check("held_no_reflush", 32'(busy), 0);

    // Underflow sets a sticky error; reset clears it
    instr_rvalid = 1'b1;
    tick();
    instr_rvalid = 1'b0;
    check("uflow_err", 32'(err), 1);
    repeat (3) tick();
    check("uflow_sticky", 32'(err), 1);
    rst_n = 1'b0;
    #1;
    check("uflow_rst_err", 32'(err), 0);
    tick();
    rst_n = 1'b1;
    tick();

    // Overflow: third handshake with MAX_OUTSTANDING=2
    handshakes(2);
    check("oflow_pre_err", 32'(err), 0);
    handshakes(1);
    check("oflow_err", 32'(err), 1);
    instr_rvalid = 1'b1;
    repeat (2) tick();
    instr_rvalid = 1'b0;
    check("oflow_sticky", 32'(err), 1);

    // Reset during INVAL at line 5
    fencei_req = 1'b1;
    inval_gnt  = 1'b1;
    hit        = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (inval_req && inval_idx == IW'(5)) begin
        hit = 1'b1;
        break;
      end
    end
    check("rst_reach_idx5", 32'(hit), 1);
    rst_n = 1'b0;
    #1;
    check_all_zero("midrst");
    fencei_req = 1'b0;
    tick();
    rst_n = 1'b1;
    tick();
    check_all_zero("post_rst");
    flush_run(-1, -1, -1, -1, 0, fi, ac);
    check("restart_first_inval", 32'(fi), 2);
    check("restart_ack_cyc",     32'(ac), 18);
    finish_flush(1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
